// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO with one-cycle registered read data onto a valid/ready
// stream through a 3-entry circular register buffer. fifo_pop is derived only from local
// registers, rst and fifo_empty, so out_ready never reaches fifo_pop combinationally.
// Optional packet framing (beat counter driving out_last from cfg_len) is compiled in when
// the macro FIFO_STREAM_READER_LAST_EN is defined; otherwise out_last is tied low.
module fifo_stream_reader #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_pop,
   input  logic [DATA_WIDTH-1:0] fifo_pop_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            buf_count,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   output logic                  out_last
);

   logic [DATA_WIDTH-1:0] buf_q [3];
   logic [1:0]            head_q, head_d;
   logic [1:0]            tail_q, tail_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q;
   logic                  take;
   logic                  capture;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Reserve a slot for every word already buffered or still coming back from the FIFO.
   assign fifo_pop  = !rst && !fifo_empty && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
   assign capture   = inflight_q;
   assign take      = out_valid && out_ready;
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = buf_q[head_q];
   assign buf_count = occ_q;

   // Next-state pointers and occupancy from capture/take.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (capture) begin
         tail_d = ptr_inc(tail_q);
      end
      if (take) begin
         head_d = ptr_inc(head_q);
      end
      case ({capture, take})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   // Buffer, pointers, occupancy and in-flight flag; reset discards everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= 2'd0;
         tail_q     <= 2'd0;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         occ_q      <= occ_d;
         inflight_q <= fifo_pop;
         if (capture) begin
            buf_q[tail_q] <= fifo_pop_data;
         end
      end
   end

`ifndef SYNTHESIS
   // A full buffer must never have a word still in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(occ_q == 2'd3 && inflight_q))
            else $error("fifo_stream_reader: buffer overrun (occ=3 with word in flight)");
      end
   end
`endif

`ifdef FIFO_STREAM_READER_LAST_EN
   logic [LEN_WIDTH-1:0] beat_q;
   logic [LEN_WIDTH-1:0] last_beat;

   // cfg_len of 0 behaves as a 1-word packet.
   assign last_beat = (cfg_len == '0) ? '0 : cfg_len - LEN_WIDTH'(1);
   assign out_last  = out_valid && (beat_q == last_beat);

   // Beat counter: counts takes, wraps after the last word of a packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q <= '0;
      end else if (take) begin
         beat_q <= out_last ? '0 : beat_q + LEN_WIDTH'(1);
      end
   end
`else
   logic unused_cfg_len;

   assign unused_cfg_len = ^cfg_len;
   assign out_last       = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO stands in for fifo_simple, a scoreboard
// holds every accepted word in push order, and a negedge process checks the stream.
module tb_fifo_stream_reader;

   localparam int DW    = 16;
   localparam int LW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty = 1'b1;
   logic          fifo_pop;
   logic [DW-1:0] fifo_pop_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [1:0]    buf_count;
   logic [LW-1:0] cfg_len = '0;
   logic          out_last;

   always #5 clk = ~clk;

   fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_pop     (fifo_pop),
      .fifo_pop_data(fifo_pop_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .buf_count    (buf_count),
      .cfg_len      (cfg_len),
      .out_last     (out_last)
   );

   logic [DW-1:0] fq[$];          // FIFO contents
   logic [DW-1:0] exp_q[$];       // accepted words not yet delivered
   logic [DW-1:0] delivered[$];
   int            deliv_cyc[$];
   logic          deliv_last[$];
   logic [DW-1:0] next_word = 16'h1000;
   logic          push = 1'b0;
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            beats = 0;
   int            eff_len;
   logic          run_chk = 1'b0;
   logic          stall_q = 1'b0;
   logic          rst_q = 1'b1;
   logic [DW-1:0] stall_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // One clock: sample DUT at negedge, then update the FIFO model after the edge.
   task automatic step(output logic pop_s, output logic valid_s);
      logic full;
      @(negedge clk);
      pop_s   = fifo_pop;
      valid_s = out_valid;
      full    = (fq.size() == DEPTH);
      @(posedge clk);
      #1;
      if (rst) begin
         fq.delete();
         exp_q.delete();
         beats         = 0;
         fifo_pop_data = 16'hDEAD;
      end else begin
         if (pop_s) begin
            check("pop_when_empty", fq.size() != 0, 1);
            if (fq.size() != 0) fifo_pop_data = fq.pop_front();
         end
         if (push) begin
            if (!full) begin
               fq.push_back(next_word);
               exp_q.push_back(next_word);
            end
            next_word++;
         end
      end
      fifo_empty = (fq.size() == 0);
      cyc++;
   endtask

   task automatic steps(input int n);
      logic p, v;
      for (int i = 0; i < n; i++) step(p, v);
   endtask

   task automatic preload(input int n, output int rejected);
      rejected = 0;
      for (int i = 0; i < n; i++) begin
         if (fq.size() < DEPTH) begin
            fq.push_back(next_word);
            exp_q.push_back(next_word);
         end else begin
            rejected++;
         end
         next_word++;
      end
      fifo_empty = (fq.size() == 0);
   endtask

   // Per-cycle stream checks against the scoreboard.
   always @(negedge clk) begin
      if (run_chk) begin
         if (rst) check("pop_in_reset", fifo_pop, 0);
         check("valid_vs_count", out_valid, buf_count != 2'd0);
         if (stall_q && !rst_q) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, stall_data);
         end
`ifdef FIFO_STREAM_READER_LAST_EN
         eff_len = (cfg_len == '0) ? 1 : int'(cfg_len);
         check("out_last", out_last, out_valid && (((beats + 1) % eff_len) == 0));
`else
         check("out_last_tied", out_last, 0);
`endif
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_word: got %0h, expected no word (t=%0t)", out_data, $time);
            end else begin
               check("data_order", out_data, exp_q.pop_front());
            end
            delivered.push_back(out_data);
            deliv_cyc.push_back(cyc);
            deliv_last.push_back(out_last);
            beats++;
         end
         stall_q    = out_valid && !out_ready;
         stall_data = out_data;
         rst_q      = rst;
      end
   end

   initial begin
      logic p, v;
      int   rej, pops, run, maxrun, first_pop, first_valid, mark;

      // Reset with FIFO empty, then idle.
      for (int i = 0; i < 12; i++) begin
         rst = (i < 6);
         step(p, v);
         run_chk = 1'b1;
         check("idle_valid", out_valid, 0);
         check("idle_count", buf_count, 0);
         check("idle_pop", fifo_pop, 0);
         check("idle_data", out_data, 0);
      end

      // 20 words into a 16-deep FIFO, full-rate drain.
      out_ready = 1'b1;
      preload(20, rej);
      check("rejected", rej, 4);
      pops = 0; run = 0; maxrun = 0; first_pop = -1; first_valid = -1;
      for (int i = 0; i < 30; i++) begin
         step(p, v);
         if (p) begin
            pops++;
            run++;
            if (first_pop < 0) first_pop = i;
            if (run > maxrun) maxrun = run;
         end else begin
            run = 0;
         end
         if (v && first_valid < 0) first_valid = i;
      end
      check("first_pop_cycle", first_pop, 0);
      check("pop_to_valid", first_valid - first_pop, 2);
      check("pop_total", pops, 16);
      check("pop_run", maxrun, 16);
      check("deliv_count_a", delivered.size(), 16);
      check("deliv_span", deliv_cyc[15] - deliv_cyc[0], 15);
      check("first_word", delivered[0], 16'h1000);
      check("word15", delivered[15], 16'h100F);

      // Backpressure: exactly 3 pops, then hold.
      out_ready = 1'b0;
      preload(10, rej);
      pops = 0;
      for (int i = 0; i < 10; i++) begin
         step(p, v);
         if (p) pops++;
      end
      check("bp_pops", pops, 3);
      check("bp_count", buf_count, 3);
      check("bp_pop_low", fifo_pop, 0);
      out_ready = 1'b1;
      steps(20);
      check("deliv_count_b", delivered.size(), 26);
      check("bp_first_word", delivered[16], 16'h1014);
      check("bp_drained", exp_q.size(), 0);

      // Toggling ready with concurrent push/pop.
      for (int i = 0; i < 60; i++) begin
         push      = (i < 15);
         out_ready = ((i % 2) == 0);
         step(p, v);
      end
      push = 1'b0;
      out_ready = 1'b1;
      steps(4);
      check("deliv_count_c", delivered.size(), 41);
      check("toggle_last_word", delivered[40], 16'h102C);

      // Reset with two buffered words and one in flight.
      out_ready = 1'b0;
      preload(10, rej);
      pops = 0;
      for (int i = 0; i < 3; i++) begin
         step(p, v);
         if (p) pops++;
      end
      check("pre_rst_pops", pops, 3);
      check("pre_rst_count", buf_count, 2);
      rst = 1'b1;
      step(p, v);
      rst = 1'b0;
      check("rst_valid", out_valid, 0);
      check("rst_count", buf_count, 0);
      check("rst_data", out_data, 0);
      out_ready = 1'b1;
      steps(4);
      check("no_stale_output", delivered.size(), 41);
      preload(5, rej);
      steps(20);
      check("deliv_count_d", delivered.size(), 46);
      check("restart_word", delivered[41], 16'h1037);
      check("restart_drained", exp_q.size(), 0);

`ifdef FIFO_STREAM_READER_LAST_EN
      // Packet framing: cfg_len=4, then cfg_len=0.
      rst = 1'b1;
      step(p, v);
      rst = 1'b0;
      cfg_len = 8'd4;
      mark = delivered.size();
      preload(10, rej);
      steps(20);
      for (int k = 0; k < 10; k++) check("last_len4", deliv_last[mark + k], ((k + 1) % 4) == 0);
      rst = 1'b1;
      step(p, v);
      rst = 1'b0;
      cfg_len = 8'd0;
      mark = delivered.size();
      preload(5, rej);
      steps(15);
      for (int k = 0; k < 5; k++) check("last_len0", deliv_last[mark + k], 1);
`endif

      run_chk = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
